// File: rtl/invaders_pkg.sv
// Shared definitions for the invaders game blocks: shot FSM states, key codes
// and screen geometry.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLIGHT   = 2'd1,
    COOLDOWN = 2'd2
  } shot_state_t;

  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_LEFT  = 8'h04;
  localparam logic [7:0] KEY_RIGHT = 8'h07;

  localparam int unsigned SCREEN_X_MAX = 639;
  localparam int unsigned SCREEN_Y_MAX = 479;

  // Widened by one bit so y_min + step can never wrap near the top of the range.
  function automatic logic reached_top(input logic [9:0] y,
                                       input logic [9:0] y_min,
                                       input logic [9:0] step);
    return {1'b0, y} < ({1'b0, y_min} + {1'b0, step});
  endfunction

endpackage

// File: rtl/player_shot_ctrl_if.sv
// Signals between the shot controller and the keyboard/player, collision and
// drawing logic.
interface player_shot_ctrl_if;
  logic [7:0] keycode;
  logic [9:0] player_X;
  logic       game_enable;
  logic       hit;
  logic [9:0] bullet_X;
  logic [9:0] bullet_Y;
  logic       bullet_active;
  logic       shot_fired;
  logic       shot_missed;
  logic       busy;

  modport master (
    output keycode, player_X, game_enable, hit,
    input  bullet_X, bullet_Y, bullet_active, shot_fired, shot_missed, busy
  );

  modport slave (
    input  keycode, player_X, game_enable, hit,
    output bullet_X, bullet_Y, bullet_active, shot_fired, shot_missed, busy
  );
endinterface

// File: rtl/key_edge_detect.sv
// Registered rising-edge detector on "keycode equals KEY". RST_VAL = 1 makes
// a key held through reset look already pressed, so it must be released first.
module key_edge_detect #(
  parameter logic [7:0] KEY     = 8'h2C,
  parameter logic       RST_VAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] keycode,
  output logic       rise
);

  logic pressed;
  logic pressed_prev;

  assign pressed = (keycode == KEY);

  always_ff @(posedge clk) begin
    if (rst) pressed_prev <= RST_VAL;
    else     pressed_prev <= pressed;
  end

  assign rise = pressed & ~pressed_prev;

endmodule

// File: rtl/player_shot_ctrl.sv
// Player bullet sequencer: one-shot fire on key press, per-frame upward travel,
// retirement on hit or at the top, then a cooldown before the next shot.
//
// state    | meaning
// IDLE     | no bullet; a fresh fire press with game_enable launches
// FLIGHT   | bullet drawn and collidable, moving up one step per frame
// COOLDOWN | bullet retired; counter runs down before re-arming
module player_shot_ctrl
  import invaders_pkg::*;
#(
  parameter logic [7:0] FIRE_KEY        = KEY_SPACE,
  parameter logic [9:0] BULLET_Y_START  = 10'd440,
  parameter logic [9:0] BULLET_Y_MIN    = 10'd0,
  parameter logic [9:0] BULLET_Y_STEP   = 10'd4,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd15
) (
  input  logic         frame_clk,
  input  logic         Reset,
  player_shot_ctrl_if.slave bus
);

  shot_state_t state;
  logic [9:0]  bullet_x_q;
  logic [9:0]  bullet_y_q;
  logic        active_q;
  logic        fired_q;
  logic        missed_q;
  logic [7:0]  cool_cnt;
  logic        fire_req;

  key_edge_detect #(
    .KEY     (FIRE_KEY),
    .RST_VAL (1'b1)
  ) u_fire_edge (
    .clk     (frame_clk),
    .rst     (Reset),
    .keycode (bus.keycode),
    .rise    (fire_req)
  );

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state      <= IDLE;
      bullet_x_q <= 10'd0;
      bullet_y_q <= BULLET_Y_START;
      active_q   <= 1'b0;
      fired_q    <= 1'b0;
      missed_q   <= 1'b0;
      cool_cnt   <= 8'd0;
    end else begin
      fired_q  <= 1'b0;
      missed_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.game_enable && fire_req) begin
            state      <= FLIGHT;
            bullet_x_q <= bus.player_X;
            bullet_y_q <= BULLET_Y_START;
            active_q   <= 1'b1;
            fired_q    <= 1'b1;
          end
        end
        FLIGHT: begin
          if (!bus.game_enable) begin
            state    <= IDLE;
            active_q <= 1'b0;
          end else if (bus.hit || reached_top(bullet_y_q, BULLET_Y_MIN, BULLET_Y_STEP)) begin
            // A hit on the last visible frame still counts as a hit, not a miss.
            active_q <= 1'b0;
            missed_q <= ~bus.hit;
            if (COOLDOWN_FRAMES == 8'd0) begin
              state <= IDLE;
            end else begin
              state    <= COOLDOWN;
              cool_cnt <= COOLDOWN_FRAMES;
            end
          end else begin
            bullet_y_q <= bullet_y_q - BULLET_Y_STEP;
          end
        end
        COOLDOWN: begin
          if (!bus.game_enable) begin
            state    <= IDLE;
            cool_cnt <= 8'd0;
          end else begin
            cool_cnt <= cool_cnt - 8'd1;
            if (cool_cnt == 8'd1) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bullet_X      = bullet_x_q;
  assign bus.bullet_Y      = bullet_y_q;
  assign bus.bullet_active = active_q;
  assign bus.shot_fired    = fired_q;
  assign bus.shot_missed   = missed_q;
  assign bus.busy          = (state != IDLE);

endmodule
